// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with valid/ready handshake, flush,
// optional 2-entry skid buffer (registered in_ready) and a saturating stall counter.
module pipe_stage_reg #(
    parameter int                 WIDTH     = 71,
    parameter bit                 SKID      = 1'b1,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0,
    parameter int                 CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             accept;
    logic             emit;
    logic             load_main;
    logic             load_skid;
    logic             main_from_skid;

    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign accept    = in_valid & in_ready;
    assign emit      = out_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            // data regs are left alone; out_data is don't-care once out_valid drops
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d   = HALF;
                        load_main = 1'b1;
                    end
                end
                HALF: begin
                    if (accept && emit) begin
                        load_main = 1'b1;
                    end else if (accept) begin
                        state_d   = FULL;
                        load_skid = 1'b1;
                    end else if (emit) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (emit) begin
                        state_d        = HALF;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_q <= RESET_VAL;
            skid_q <= RESET_VAL;
        end else begin
            if (load_main) begin
                main_q <= in_data;
            end else if (main_from_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

    generate
        if (SKID) begin : g_skid
            // Registered ready: upstream never sees a combinational path from out_ready.
            logic ready_q;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    ready_q <= 1'b1;
                end else begin
                    ready_q <= (state_d != FULL);
                end
            end
            assign in_ready = ready_q;
        end else begin : g_noskid
            assign in_ready = !out_valid || out_ready;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (clr_cnt) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one skid instance (CNT_W=4) and one single-register
// instance, both checked every cycle against a queue-based reference model.
module tb_pipe_stage_reg;

    localparam logic [70:0] RV1 = 71'h0ABC;

    logic        clk;
    logic        rst;

    logic        in_valid0, in_ready0, flush0, out_valid0, out_ready0, clr0;
    logic [70:0] in_data0, out_data0;
    logic [15:0] stall0;

    logic        in_valid1, in_ready1, flush1, out_valid1, out_ready1, clr1;
    logic [70:0] in_data1, out_data1;
    logic [3:0]  stall1;

    int checks = 0;
    int errors = 0;

    logic [70:0] q0[$];
    logic [70:0] q1[$];
    int          cnt0 = 0;
    int          cnt1 = 0;

    logic [70:0] val_a, val_b, val_c, val_d, val_e;

    pipe_stage_reg #(.WIDTH(71), .SKID(1'b0), .RESET_VAL(71'h0), .CNT_W(16)) u_reg (
        .clk(clk), .rst(rst),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
        .flush(flush0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
        .clr_cnt(clr0), .stall_cnt(stall0)
    );

    pipe_stage_reg #(.WIDTH(71), .SKID(1'b1), .RESET_VAL(RV1), .CNT_W(4)) u_skid (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .flush(flush1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .clr_cnt(clr1), .stall_cnt(stall1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [70:0] rnd71();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[70:0];
    endfunction

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check both DUTs at the falling edge against the model, advance
    // the model by the handshake rules, then return 1 time unit after the rising edge.
    task automatic tick();
        logic ev0, er0, ev1, er1;
        logic acc0, emt0, acc1, emt1;
        @(negedge clk);
        ev0 = (q0.size() > 0);
        er0 = (q0.size() == 0) || out_ready0;
        ev1 = (q1.size() > 0);
        er1 = (q1.size() < 2);
        chk("u0_out_valid", 80'(out_valid0), 80'(ev0));
        chk("u0_in_ready", 80'(in_ready0), 80'(er0));
        chk("u0_stall_cnt", 80'(stall0), 80'(cnt0));
        if (ev0) chk("u0_out_data", 80'(out_data0), 80'(q0[0]));
        chk("u1_out_valid", 80'(out_valid1), 80'(ev1));
        chk("u1_in_ready", 80'(in_ready1), 80'(er1));
        chk("u1_stall_cnt", 80'(stall1), 80'(cnt1));
        if (ev1) chk("u1_out_data", 80'(out_data1), 80'(q1[0]));
        if (rst) begin
            acc0 = in_valid0 && er0;
            emt0 = ev0 && out_ready0;
            if (flush0) q0.delete();
            else begin
                if (emt0) void'(q0.pop_front());
                if (acc0) q0.push_back(in_data0);
            end
            if (clr0) cnt0 = 0;
            else if (ev0 && !out_ready0 && cnt0 != 65535) cnt0++;

            acc1 = in_valid1 && er1;
            emt1 = ev1 && out_ready1;
            if (flush1) q1.delete();
            else begin
                if (emt1) void'(q1.pop_front());
                if (acc1) q1.push_back(in_data1);
            end
            if (clr1) cnt1 = 0;
            else if (ev1 && !out_ready1 && cnt1 != 15) cnt1++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        {in_valid0, flush0, out_ready0, clr0} = '0;
        {in_valid1, flush1, out_ready1, clr1} = '0;
        in_data0 = '0;
        in_data1 = '0;
        val_a = rnd71(); val_b = rnd71(); val_c = rnd71(); val_d = rnd71(); val_e = rnd71();

        // Reset state
        tick();
        tick();
        chk("rst_u0_out_valid", 80'(out_valid0), 80'(1'b0));
        chk("rst_u0_in_ready", 80'(in_ready0), 80'(1'b1));
        chk("rst_u0_out_data", 80'(out_data0), 80'(71'h0));
        chk("rst_u1_out_valid", 80'(out_valid1), 80'(1'b0));
        chk("rst_u1_in_ready", 80'(in_ready1), 80'(1'b1));
        chk("rst_u1_out_data", 80'(out_data1), 80'(RV1));
        chk("rst_u1_stall_cnt", 80'(stall1), 80'(4'd0));
        rst = 1'b1;
        tick();

        // Single transfer with downstream ready
        in_valid0 = 1'b1; in_data0 = 71'h1234; out_ready0 = 1'b1;
        in_valid1 = 1'b1; in_data1 = 71'h1234; out_ready1 = 1'b1;
        tick();
        in_valid0 = 1'b0; in_valid1 = 1'b0;
        chk("t1_u0_out_valid", 80'(out_valid0), 80'(1'b1));
        chk("t1_u0_out_data", 80'(out_data0), 80'(71'h1234));
        chk("t1_u0_in_ready", 80'(in_ready0), 80'(1'b1));
        chk("t1_u1_out_data", 80'(out_data1), 80'(71'h1234));
        chk("t1_u1_in_ready", 80'(in_ready1), 80'(1'b1));
        tick();

        // Skid fill under backpressure, then drain in order
        out_ready1 = 1'b0;
        in_valid1 = 1'b1; in_data1 = val_a; tick();
        in_data1 = val_b; tick();
        in_valid1 = 1'b0;
        chk("t2_full_in_ready", 80'(in_ready1), 80'(1'b0));
        chk("t2_head_a", 80'(out_data1), 80'(val_a));
        out_ready1 = 1'b1;
        tick();
        chk("t2_then_b", 80'(out_data1), 80'(val_b));
        chk("t2_ready_back", 80'(in_ready1), 80'(1'b1));
        tick();
        chk("t2_drained", 80'(out_valid1), 80'(1'b0));

        // Flush while full drops everything, including the input offered that cycle
        out_ready1 = 1'b0;
        in_valid1 = 1'b1; in_data1 = val_c; tick();
        in_data1 = val_d; tick();
        flush1 = 1'b1; in_data1 = val_e;
        tick();
        flush1 = 1'b0; in_valid1 = 1'b0;
        chk("t3_out_valid", 80'(out_valid1), 80'(1'b0));
        chk("t3_in_ready", 80'(in_ready1), 80'(1'b1));
        out_ready1 = 1'b1;
        tick();
        tick();

        // Stall counter saturation and clear
        clr1 = 1'b1; out_ready1 = 1'b0; in_valid1 = 1'b1; in_data1 = val_a;
        tick();
        clr1 = 1'b0; in_valid1 = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("t4_saturated", 80'(stall1), 80'(4'd15));
        clr1 = 1'b1;
        tick();
        clr1 = 1'b0;
        chk("t4_cleared", 80'(stall1), 80'(4'd0));

        // Asynchronous reset while full
        in_valid1 = 1'b1; in_data1 = val_b;
        tick();
        in_valid1 = 1'b0;
        chk("t5_pre_full", 80'(in_ready1), 80'(1'b0));
        #2;
        rst = 1'b0;
        #1;
        chk("t5_out_valid", 80'(out_valid1), 80'(1'b0));
        chk("t5_out_data", 80'(out_data1), 80'(RV1));
        chk("t5_in_ready", 80'(in_ready1), 80'(1'b1));
        chk("t5_stall_cnt", 80'(stall1), 80'(4'd0));
        q0.delete(); q1.delete(); cnt0 = 0; cnt1 = 0;
        tick();
        rst = 1'b1;
        tick();

        // Random traffic on both instances
        for (int i = 0; i < 1000; i++) begin
            in_valid0  = ($urandom_range(0, 1) == 1);
            out_ready0 = ($urandom_range(0, 2) != 0);
            in_data0   = rnd71();
            in_valid1  = ($urandom_range(0, 1) == 1);
            out_ready1 = ($urandom_range(0, 2) != 0);
            in_data1   = rnd71();
            flush1     = ($urandom_range(0, 15) == 0);
            clr1       = ($urandom_range(0, 31) == 0);
            tick();
        end
        {in_valid0, flush1, clr1, in_valid1} = '0;
        out_ready0 = 1'b1; out_ready1 = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("end_u0_empty", 80'(out_valid0), 80'(1'b0));
        chk("end_u1_empty", 80'(out_valid1), 80'(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
